seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator_if.sv | 29 ++
 rtl/seq_magnitude_comparator.sv | 118 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result bundle for seq_magnitude_comparator.
// The producer drives a/b/is_signed and consumes eq/gt/lt; the comparator is the slave.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  // Handshake rules: a transfer happens on a rising clock edge where valid && ready.
  // A source that raises valid keeps valid and its payload unchanged until that transfer.
  // ready may change freely and never depends on valid in the same cycle.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, eq, gt, lt
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, eq, gt, lt
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, with signed mode.
// Optional macro SEQ_CMP_EARLY_EXIT_EN ends the scan at the first differing chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  seq_magnitude_comparator_if.slave   bus,
  output logic [1:0]                  state_dbg
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_magnitude_comparator: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_acc;
  logic             gt_acc;
  logic [IDX_W-1:0] idx;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic [WIDTH-1:0] msb_mask;
  logic [CHUNK-1:0] ac;
  logic [CHUNK-1:0] bc;
  logic             eq_nx;
  logic             gt_nx;
  logic             early_exit;
  logic             scan_done;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    msb_mask          = '0;
    msb_mask[WIDTH-1] = bus.is_signed;
  end

  always_comb begin
    ac    = a_q[idx*CHUNK +: CHUNK];
    bc    = b_q[idx*CHUNK +: CHUNK];
    eq_nx = eq_acc;
    gt_nx = gt_acc;
    if (eq_acc) begin
      eq_nx = (ac == bc);
      gt_nx = (ac > bc);
    end
`ifdef SEQ_CMP_EARLY_EXIT_EN
    early_exit = eq_acc && (ac != bc);
`else
    early_exit = 1'b0;
`endif
    scan_done = (idx == '0) || early_exit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
      idx    <= '0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a ^ msb_mask;
            b_q    <= bus.b ^ msb_mask;
            eq_acc <= 1'b1;
            gt_acc <= 1'b0;
            idx    <= IDX_W'(NCHUNK - 1);
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          eq_acc <= eq_nx;
          gt_acc <= gt_nx;
          if (scan_done) begin
            // Result registers load on the same edge as the last scanned chunk.
            eq_q  <= eq_nx;
            gt_q  <= gt_nx;
            lt_q  <= !eq_nx && !gt_nx;
            state <= S_DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: directed vectors, backpressure, mid-op reset and
// random traffic; expected {eq,gt,lt} and latency are queued by the driver, checked by a monitor.
module tb_seq_magnitude_comparator;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();
  logic [1:0] state_dbg;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];
  int         lat_q[$];
  time        acc_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         rdy_mode = 0;
  time        last_acc_time = 0;
  time        last_hs_time  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic e, g;
    e = (a == b);
    g = s ? ($signed(a) > $signed(b)) : (a > b);
    return {e, g, !e && !g};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    if (!EARLY || x == 32'd0) return NCHUNK;
    for (int k = NCHUNK - 1; k >= 0; k--) begin
      if (x[k*CHUNK +: CHUNK] != '0) return NCHUNK - k;
    end
    return NCHUNK;
  endfunction

  // ---------------- consumer readiness ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 9) < 7);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [2:0] exp, input int lat);
    int   waited;
    logic ok;
    @(negedge clock);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    ok = bus.in_ready;
    check("accept_wait", 32'(ok), 32'd1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    last_acc_time = $time;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_q.push_back($time);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = ~a;
    bus.b         = a;
    bus.is_signed = ~s;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  logic       seen_rise = 1'b0;
  logic       prev_hold = 1'b0;
  logic [2:0] held      = 3'b000;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        seen_rise = 1'b0;
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_result", 32'({bus.eq, bus.gt, bus.lt}), 32'(held));
      end
      if (bus.out_valid) begin
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        check("onehot", 32'($countones({bus.eq, bus.gt, bus.lt})), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_out: out_valid with no pending op at %0t", $time);
        end else begin
          if (!seen_rise) begin
            seen_rise = 1'b1;
            check("latency", 32'(($time - 5 - acc_q[0]) / 10), 32'(lat_q[0]));
          end
          if (bus.out_ready) begin
            check("result", 32'({bus.eq, bus.gt, bus.lt}), 32'(exp_q.pop_front()));
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            last_hs_time = $time + 5;
            seen_rise    = 1'b0;
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      held      = {bus.eq, bus.gt, bus.lt};
    end
  end

  // ---------------- stimulus ----------------
  localparam int L1 = EARLY ? 1 : NCHUNK;

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          w;
    logic [31:0] corners[5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_eq_gt_lt", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // Directed vectors, expected {eq,gt,lt} worked out by hand.
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, L1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, L1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b001, L1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3'b010, L1);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b100, NCHUNK);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b100, NCHUNK);
    send(32'hC000_0000, 32'h4000_0000, 1'b0, 3'b010, L1);
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 3'b001, NCHUNK);
    wait_drain();

    // Backpressure: result held 5 cycles, next op waits for the output handshake.
    rdy_mode = 2;
    @(posedge clock);
    send(32'd7, 32'd1, 1'b0, 3'b010, EARLY ? 15 : NCHUNK);
    fork
      begin
        w = 0;
        while (!bus.out_valid && w < 40) begin
          @(negedge clock);
          w++;
        end
        check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (5) @(negedge clock);
        rdy_mode = 0;
      end
      send(32'd5, 32'd5, 1'b0, 3'b100, NCHUNK);
    join
    check("bp_accept_after_hs", 32'(last_acc_time - last_hs_time), 32'd10);
    wait_drain();

    // Reset during SCAN aborts the operation.
    send(32'd3, 32'd9, 1'b0, 3'b001, NCHUNK);
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_eq_gt_lt", 32'({bus.eq, bus.gt, bus.lt}), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(negedge clock);
    reset = 1'b0;
    send(32'd9, 32'd3, 1'b0, 3'b010, EARLY ? 15 : NCHUNK);
    wait_drain();

    // Random traffic with random gaps and consumer stalls.
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      rs = 1'(($urandom_range(0, 1)));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = $urandom();
        1:       rb = ra;
        2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: begin
          ra = corners[$urandom_range(0, 4)];
          rb = corners[$urandom_range(0, 4)];
        end
      endcase
      send(ra, rb, rs, ref_cmp(ra, rb, rs), ref_lat(ra, rb));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
